atm: RTL and testbench

- Single-account ATM controller for a Basys-class board.
- Three push-buttons (BTN3/BTN2/BTN1) and a 4-bit switch bank drive an FSM covering card insert, login, menu, deposit/withdraw, password change and timed lockouts.
- Current state, attempt status and balance are shown on 8 LEDs and four 7-segment digit drivers.
- Buttons arrive pre-debounced; the block is top-level user logic.

---
 rtl/atm.sv | 193 +++++++++++++++++++
 tb/tb_atm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/atm.sv
// Single-account ATM controller.
// Pre-debounced buttons are edge-detected against a registered history and
// drive an FSM covering card insert, login, menu, deposit/withdraw,
// password change and timed lockouts. All outputs decode registers only.
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  asynchronous active-high reset
//   BTN3    in   1  enter / confirm / deposit
//   BTN2    in   1  withdraw / password change
//   BTN1    in   1  back / logout
//   SW      in   4  password or amount entry
//   LED     out  8  [6:0] one-hot state, [7] attempts != 0
//   digit4  out  7  state code        (active-low {g,f,e,d,c,b,a})
//   digit3  out  7  attempts
//   digit2  out  7  balance[7:4]
//   digit1  out  7  balance[3:0]
module atm #(
  parameter int unsigned LOCK_LONG_CYCLES  = 50,
  parameter int unsigned LOCK_SHORT_CYCLES = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BTN3,
  input  logic       BTN2,
  input  logic       BTN1,
  input  logic [3:0] SW,
  output logic [7:0] LED,
  output logic [6:0] digit4,
  output logic [6:0] digit3,
  output logic [6:0] digit2,
  output logic [6:0] digit1
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PASS   = 3'd1,
    MENU   = 3'd2,
    MONEY  = 3'd3,
    PW_OLD = 3'd4,
    PW_NEW = 3'd5,
    LOCK   = 3'd6
  } state_t;

  state_t      state, state_n;
  state_t      ret_state, ret_state_n;
  logic [3:0]  password, password_n;
  logic [7:0]  balance, balance_n;
  logic [1:0]  attempts, attempts_n;
  logic [31:0] lock_timer, lock_timer_n;
  logic [2:0]  btn_hist;

  logic [2:0]  press;
  logic        go3, go2, go1;
  logic [8:0]  sum;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ret_state  <= IDLE;
      password   <= 4'd0;
      balance    <= 8'd0;
      attempts   <= 2'd0;
      lock_timer <= 32'd0;
      btn_hist   <= 3'd0;
    end else begin
      state      <= state_n;
      ret_state  <= ret_state_n;
      password   <= password_n;
      balance    <= balance_n;
      attempts   <= attempts_n;
      lock_timer <= lock_timer_n;
      // History keeps tracking during LOCK so a button held across the end
      // of a lockout does not fire on exit.
      btn_hist   <= {BTN3, BTN2, BTN1};
    end
  end

  // Rising-edge detect with fixed priority BTN3 > BTN2 > BTN1.
  assign press = {BTN3, BTN2, BTN1} & ~btn_hist;
  assign go3   = press[2];
  assign go2   = press[1] & ~press[2];
  assign go1   = press[0] & ~press[2] & ~press[1];
  // Ninth bit flags a deposit that would overflow the 8-bit balance.
  assign sum   = {1'b0, balance} + {5'd0, SW};

  always_comb begin
    state_n      = state;
    ret_state_n  = ret_state;
    password_n   = password;
    balance_n    = balance;
    attempts_n   = attempts;
    lock_timer_n = lock_timer;
    case (state)
      IDLE: begin
        if (go3) begin
          state_n    = PASS;
          attempts_n = 2'd0;
        end
      end
      PASS, PW_OLD: begin
        if (go3) begin
          if (SW == password) begin
            state_n    = (state == PASS) ? MENU : PW_NEW;
            attempts_n = 2'd0;
          end else if (attempts == 2'd2) begin
            // Third wrong entry: long lockout, then logged out.
            state_n      = LOCK;
            ret_state_n  = IDLE;
            lock_timer_n = 32'(LOCK_LONG_CYCLES);
            attempts_n   = 2'd0;
          end else begin
            attempts_n = attempts + 2'd1;
          end
        end else if (go1) begin
          state_n = (state == PASS) ? IDLE : MENU;
        end
      end
      MENU: begin
        if (go3) begin
          state_n = MONEY;
        end else if (go2) begin
          state_n    = PW_OLD;
          attempts_n = 2'd0;
        end else if (go1) begin
          state_n = IDLE;
        end
      end
      MONEY: begin
        if (go3) begin
          if (!sum[8]) balance_n = sum[7:0];
        end else if (go2) begin
          if ({4'd0, SW} <= balance) begin
            balance_n = balance - {4'd0, SW};
          end else begin
            state_n      = LOCK;
            ret_state_n  = MONEY;
            lock_timer_n = 32'(LOCK_SHORT_CYCLES);
          end
        end else if (go1) begin
          state_n = MENU;
        end
      end
      PW_NEW: begin
        if (go3) begin
          password_n = SW;
          state_n    = MENU;
        end else if (go1) begin
          state_n = MENU;
        end
      end
      LOCK: begin
        // Timer holds N on the first LOCK cycle; leaving when it reads 1
        // gives exactly N cycles in LOCK. Buttons are not consulted here.
        if (lock_timer <= 32'd1) begin
          state_n      = ret_state;
          lock_timer_n = 32'd0;
        end else begin
          lock_timer_n = lock_timer - 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign LED    = {(attempts != 2'd0), 7'(7'd1 << state)};
  assign digit4 = seg7({1'b0, state});
  assign digit3 = seg7({2'b00, attempts});
  assign digit2 = seg7(balance[7:4]);
  assign digit1 = seg7(balance[3:0]);

endmodule

// File: tb/tb_atm.sv
// Directed bench for the ATM controller: walks the login / deposit /
// withdraw / password / lockout flows and the edge cases, checking LEDs and
// 7-segment outputs against hand-computed values.
module tb_atm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       BTN3 = 1'b0, BTN2 = 1'b0, BTN1 = 1'b0;
  logic [3:0] SW = 4'd0;
  logic [7:0] LED;
  logic [6:0] digit4, digit3, digit2, digit1;

  int vectors = 0;
  int miscompares = 0;

  atm #(.LOCK_LONG_CYCLES(50), .LOCK_SHORT_CYCLES(25)) dut (
    .clk(clk), .rst(rst), .BTN3(BTN3), .BTN2(BTN2), .BTN1(BTN1), .SW(SW),
    .LED(LED), .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // One-cycle button pulse; returns at the negedge after the acting edge.
  task automatic press(input logic [2:0] m, input logic [3:0] s);
    @(negedge clk);
    SW = s;
    {BTN3, BTN2, BTN1} = m;
    @(negedge clk);
    {BTN3, BTN2, BTN1} = 3'b000;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (LED !== 8'h01) begin miscompares++; $display("FAIL reset_led got %h want %h", LED, 8'h01); end
    vectors++; if (digit4 !== 7'h40) begin miscompares++; $display("FAIL reset_d4 got %h want %h", digit4, 7'h40); end
    vectors++; if ({digit3, digit2, digit1} !== {7'h40, 7'h40, 7'h40}) begin miscompares++; $display("FAIL reset_d321 got %h want %h", {digit3, digit2, digit1}, {7'h40, 7'h40, 7'h40}); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (LED !== 8'h01) begin miscompares++; $display("FAIL reset_release_led got %h want %h", LED, 8'h01); end
  endtask

  task automatic test_deposit;
    press(3'b100, 4'd0);
    vectors++; if (LED !== 8'h02) begin miscompares++; $display("FAIL dep_pass got %h want %h", LED, 8'h02); end
    press(3'b100, 4'd0);
    vectors++; if (LED !== 8'h04) begin miscompares++; $display("FAIL dep_menu got %h want %h", LED, 8'h04); end
    press(3'b100, 4'd0);
    vectors++; if (LED !== 8'h08) begin miscompares++; $display("FAIL dep_money got %h want %h", LED, 8'h08); end
    vectors++; if (digit4 !== 7'h30) begin miscompares++; $display("FAIL dep_d4 got %h want %h", digit4, 7'h30); end
    press(3'b100, 4'd5);
    vectors++; if ({digit2, digit1} !== {7'h40, 7'h12}) begin miscompares++; $display("FAIL dep_bal5 got %h want %h", {digit2, digit1}, {7'h40, 7'h12}); end
    press(3'b001, 4'd0);
    vectors++; if (LED !== 8'h04) begin miscompares++; $display("FAIL dep_back got %h want %h", LED, 8'h04); end
  endtask

  task automatic test_pw_change_and_login_lock;
    press(3'b010, 4'd0);
    vectors++; if (LED !== 8'h10) begin miscompares++; $display("FAIL pw_old got %h want %h", LED, 8'h10); end
    press(3'b100, 4'd0);
    vectors++; if (LED !== 8'h20) begin miscompares++; $display("FAIL pw_new got %h want %h", LED, 8'h20); end
    press(3'b100, 4'd9);
    vectors++; if (LED !== 8'h04) begin miscompares++; $display("FAIL pw_set_menu got %h want %h", LED, 8'h04); end
    press(3'b001, 4'd0);
    vectors++; if (LED !== 8'h01) begin miscompares++; $display("FAIL logout got %h want %h", LED, 8'h01); end
    press(3'b100, 4'd0);
    press(3'b100, 4'd0);
    vectors++; if ({LED, digit3} !== {8'h82, 7'h79}) begin miscompares++; $display("FAIL wrong1 got %h want %h", {LED, digit3}, {8'h82, 7'h79}); end
    press(3'b100, 4'd4);
    vectors++; if ({LED, digit3} !== {8'h82, 7'h24}) begin miscompares++; $display("FAIL wrong2 got %h want %h", {LED, digit3}, {8'h82, 7'h24}); end
    press(3'b100, 4'd2);
    vectors++; if ({LED, digit4, digit3} !== {8'h40, 7'h02, 7'h40}) begin miscompares++; $display("FAIL wrong3_lock got %h want %h", {LED, digit4, digit3}, {8'h40, 7'h02, 7'h40}); end
    for (int i = 1; i < 50; i++) begin
      @(negedge clk);
      {BTN3, BTN2, BTN1} = (i % 7 == 3) ? 3'b111 : 3'b000;
    end
    vectors++; if (LED !== 8'h40) begin miscompares++; $display("FAIL long_lock_hold got %h want %h", LED, 8'h40); end
    @(negedge clk);
    vectors++; if (LED !== 8'h01) begin miscompares++; $display("FAIL long_lock_exit got %h want %h", LED, 8'h01); end
  endtask

  task automatic test_withdraw;
    press(3'b100, 4'd0);
    press(3'b100, 4'd9);
    vectors++; if (LED !== 8'h04) begin miscompares++; $display("FAIL newpw_login got %h want %h", LED, 8'h04); end
    press(3'b100, 4'd0);
    press(3'b010, 4'd4);
    vectors++; if ({LED, digit2, digit1} !== {8'h08, 7'h40, 7'h79}) begin miscompares++; $display("FAIL wd4 got %h want %h", {LED, digit2, digit1}, {8'h08, 7'h40, 7'h79}); end
    press(3'b010, 4'd2);
    vectors++; if ({LED, digit1} !== {8'h40, 7'h79}) begin miscompares++; $display("FAIL wd_short_lock got %h want %h", {LED, digit1}, {8'h40, 7'h79}); end
    repeat (24) @(negedge clk);
    vectors++; if (LED !== 8'h40) begin miscompares++; $display("FAIL short_lock_hold got %h want %h", LED, 8'h40); end
    @(negedge clk);
    vectors++; if ({LED, digit1} !== {8'h08, 7'h79}) begin miscompares++; $display("FAIL short_lock_exit got %h want %h", {LED, digit1}, {8'h08, 7'h79}); end
  endtask

  task automatic test_pw_old_lock;
    press(3'b001, 4'd0);
    press(3'b010, 4'd0);
    press(3'b100, 4'd4);
    vectors++; if ({LED, digit3} !== {8'h90, 7'h79}) begin miscompares++; $display("FAIL pwold_w1 got %h want %h", {LED, digit3}, {8'h90, 7'h79}); end
    press(3'b100, 4'd0);
    vectors++; if ({LED, digit3} !== {8'h90, 7'h24}) begin miscompares++; $display("FAIL pwold_w2 got %h want %h", {LED, digit3}, {8'h90, 7'h24}); end
    press(3'b100, 4'd14);
    vectors++; if ({LED, digit3} !== {8'h40, 7'h40}) begin miscompares++; $display("FAIL pwold_lock got %h want %h", {LED, digit3}, {8'h40, 7'h40}); end
    repeat (49) @(negedge clk);
    vectors++; if (LED !== 8'h40) begin miscompares++; $display("FAIL pwold_lock_hold got %h want %h", LED, 8'h40); end
    @(negedge clk);
    vectors++; if ({LED, digit3} !== {8'h01, 7'h40}) begin miscompares++; $display("FAIL pwold_lock_exit got %h want %h", {LED, digit3}, {8'h01, 7'h40}); end
  endtask

  task automatic test_overflow;
    press(3'b100, 4'd0);
    press(3'b100, 4'd9);
    press(3'b100, 4'd0);
    for (int i = 0; i < 16; i++) press(3'b100, 4'd15);
    press(3'b100, 4'd9);
    vectors++; if ({digit2, digit1} !== {7'h0E, 7'h08}) begin miscompares++; $display("FAIL bal250 got %h want %h", {digit2, digit1}, {7'h0E, 7'h08}); end
    press(3'b100, 4'd15);
    vectors++; if ({LED, digit2, digit1} !== {8'h08, 7'h0E, 7'h08}) begin miscompares++; $display("FAIL dep_reject got %h want %h", {LED, digit2, digit1}, {8'h08, 7'h0E, 7'h08}); end
    press(3'b100, 4'd5);
    vectors++; if ({digit2, digit1} !== {7'h0E, 7'h0E}) begin miscompares++; $display("FAIL bal255 got %h want %h", {digit2, digit1}, {7'h0E, 7'h0E}); end
    press(3'b100, 4'd1);
    vectors++; if ({digit2, digit1} !== {7'h0E, 7'h0E}) begin miscompares++; $display("FAIL dep_reject1 got %h want %h", {digit2, digit1}, {7'h0E, 7'h0E}); end
    press(3'b010, 4'd0);
    vectors++; if ({LED, digit1} !== {8'h08, 7'h0E}) begin miscompares++; $display("FAIL wd_zero got %h want %h", {LED, digit1}, {8'h08, 7'h0E}); end
  endtask

  task automatic test_simultaneous_and_hold;
    press(3'b001, 4'd0);
    press(3'b101, 4'd0);
    vectors++; if (LED !== 8'h08) begin miscompares++; $display("FAIL simul_money got %h want %h", LED, 8'h08); end
    press(3'b001, 4'd0);
    @(negedge clk);
    SW = 4'd0; BTN3 = 1'b1;
    repeat (5) @(negedge clk);
    BTN3 = 1'b0;
    vectors++; if (LED !== 8'h08) begin miscompares++; $display("FAIL hold3_money got %h want %h", LED, 8'h08); end
    @(negedge clk);
    SW = 4'd5; BTN2 = 1'b1;
    repeat (5) @(negedge clk);
    BTN2 = 1'b0;
    vectors++; if ({LED, digit2, digit1} !== {8'h08, 7'h0E, 7'h08}) begin miscompares++; $display("FAIL hold2_once got %h want %h", {LED, digit2, digit1}, {8'h08, 7'h0E, 7'h08}); end
  endtask

  task automatic test_reset_in_lock;
    press(3'b001, 4'd0);
    press(3'b001, 4'd0);
    press(3'b100, 4'd0);
    press(3'b100, 4'd0);
    press(3'b100, 4'd1);
    press(3'b100, 4'd2);
    vectors++; if (LED !== 8'h40) begin miscompares++; $display("FAIL rl_lock got %h want %h", LED, 8'h40); end
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if ({LED, digit2, digit1} !== {8'h01, 7'h40, 7'h40}) begin miscompares++; $display("FAIL rl_async got %h want %h", {LED, digit2, digit1}, {8'h01, 7'h40, 7'h40}); end
    @(negedge clk);
    rst = 1'b0;
    press(3'b100, 4'd0);
    press(3'b100, 4'd0);
    vectors++; if ({LED, digit3} !== {8'h04, 7'h40}) begin miscompares++; $display("FAIL rl_pw0000 got %h want %h", {LED, digit3}, {8'h04, 7'h40}); end
  endtask

  initial begin
    test_reset;
    test_deposit;
    test_pw_change_and_login_lock;
    test_withdraw;
    test_pw_old_lock;
    test_overflow;
    test_simultaneous_and_hold;
    test_reset_in_lock;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
